gen3_scramble: RTL and testbench

//  Transmit-side 128b/130b scrambler for one PCIe Gen3 lane, placed between the TX block framer and the PIPE TX interface.

---
 rtl/gen3_scramble_pkg.sv | 54 +++++
 rtl/gen3_scramble_if.sv | 27 ++
 rtl/gen3_scramble_byte.sv | 20 ++
 rtl/gen3_scramble.sv | 125 ++++++++++++
 tb/tb_gen3_scramble.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gen3_scramble_pkg.sv
// Shared constants for the Gen3 128b/130b TX scrambler: lane seeds, ordered-set
// symbol 0 encodings, block types and the 23-bit LFSR helpers.
package gen3_scramble_pkg;

  localparam logic [22:0] LFSR_TAPS = 23'h210125;  // x^23+x^21+x^16+x^8+x^5+x^2+1

  localparam logic [22:0] gen3_seed_values [8] = '{
    23'h1DBFBC, 23'h0607BB, 23'h1EC760, 23'h18C0DB,
    23'h010F12, 23'h19CFC9, 23'h0277CE, 23'h1BB807
  };

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_OS   = 2'b10;

  localparam logic [7:0] EIEOS    = 8'h00;
  localparam logic [7:0] TS1OS    = 8'h1E;
  localparam logic [7:0] TS2OS    = 8'h2D;
  localparam logic [7:0] GEN3_SKP = 8'hAA;
  localparam logic [7:0] EIOS     = 8'h66;
  localparam logic [7:0] FTS      = 8'h55;
  localparam logic [7:0] SDS      = 8'hE1;

  typedef enum logic [2:0] {
    BT_DATA, BT_TS, BT_EIEOS, BT_BYP, BT_SKP, BT_OTHER
  } block_type_e;

  function automatic logic [22:0] lfsr_adv8(input logic [22:0] s);
    logic [22:0] v;
    v = s;
    for (int unsigned i = 0; i < 8; i++)
      v = v[22] ? ({v[21:0], 1'b0} ^ LFSR_TAPS) : {v[21:0], 1'b0};
    return v;
  endfunction

  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic block_type_e os_type(input logic [7:0] s0);
    block_type_e t;
    case (s0)
      EIEOS:            t = BT_EIEOS;
      TS1OS, TS2OS:     t = BT_TS;
      GEN3_SKP:         t = BT_SKP;
      EIOS, FTS, SDS:   t = BT_BYP;
      default:          t = BT_OTHER;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/gen3_scramble_if.sv
// Beat-level bus between the TX block framer, the scrambler and the PIPE TX side.
interface gen3_scramble_if;
  logic        scramble_reset_i;
  logic        data_valid_i;
  logic        block_start_i;
  logic [1:0]  sync_header_i;
  logic [31:0] data_in_i;
  logic        ts_dc_bypass_i;

  logic        data_valid_o;
  logic        block_start_o;
  logic [1:0]  sync_header_o;
  logic [31:0] data_out_o;
  logic        block_err_o;

  modport slave (
    input  scramble_reset_i, data_valid_i, block_start_i, sync_header_i,
           data_in_i, ts_dc_bypass_i,
    output data_valid_o, block_start_o, sync_header_o, data_out_o, block_err_o
  );

  modport master (
    output scramble_reset_i, data_valid_i, block_start_i, sync_header_i,
           data_in_i, ts_dc_bypass_i,
    input  data_valid_o, block_start_o, sync_header_o, data_out_o, block_err_o
  );
endinterface

// File: rtl/gen3_scramble_byte.sv
// One symbol slice of the scrambler chain: scramble/bypass a byte and
// optionally advance the LFSR by 8 bits.
module gen3_byte_scramble
  import gen3_scramble_pkg::*;
(
  input  logic [22:0] i_lfsr,
  input  logic [7:0]  i_data,
  input  logic        i_bypass,
  input  logic        i_advance,
  output logic [7:0]  o_data,
  output logic [22:0] o_lfsr
);

  always_comb begin
    o_data = i_data;
    if (!i_bypass) o_data = i_data ^ bit_rev8(i_lfsr[22:15]);
    o_lfsr = i_advance ? lfsr_adv8(i_lfsr) : i_lfsr;
  end

endmodule

// File: rtl/gen3_scramble.sv
// PCIe Gen3 per-lane TX scrambler, 4 symbols per beat, one-cycle registered output.
module gen3_scramble
  import gen3_scramble_pkg::*;
#(
  parameter int unsigned LANES_LOG2 = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [7:0]      lane_number,
  gen3_scramble_if.slave  bus
);

  logic [1:0]  r_cnt;
  block_type_e r_type;
  logic [22:0] r_lfsr;
  logic        r_seeded;

  logic        r_valid;
  logic        r_start;
  logic [1:0]  r_sync;
  logic [31:0] r_data;
  logic        r_err;

  logic [22:0] w_seed;
  logic [22:0] w_lfsr_cur;
  logic [1:0]  w_beat;
  block_type_e w_type;
  logic        w_err;
  logic [3:0]  w_bypass;
  logic [3:0]  w_advance;
  logic [31:0] w_data;
  logic [22:0] w_chain [5];
  logic        w_unused;

  assign w_unused = ^lane_number[7:LANES_LOG2];
  assign w_seed   = gen3_seed_values[lane_number[LANES_LOG2-1:0]];

  // Seed is applied through r_seeded rather than loaded into r_lfsr, so the
  // async reset value stays constant while still following lane_number.
  assign w_lfsr_cur = r_seeded ? r_lfsr : w_seed;
  assign w_chain[0] = w_lfsr_cur;

  always_comb begin
    w_beat = bus.block_start_i ? 2'd0 : r_cnt;
    w_type = r_type;
    w_err  = bus.block_start_i && (r_cnt != 2'd0);
    if (w_beat == 2'd0) begin
      if (!bus.block_start_i) begin
        w_type = BT_DATA;
        w_err  = 1'b1;
      end else if (bus.sync_header_i == SYNC_DATA) begin
        w_type = BT_DATA;
      end else if (bus.sync_header_i == SYNC_OS) begin
        w_type = os_type(bus.data_in_i[7:0]);
        if (w_type == BT_OTHER) w_err = 1'b1;
      end else begin
        w_type = BT_DATA;
        w_err  = 1'b1;
      end
    end
  end

  always_comb begin
    w_bypass  = '0;
    w_advance = '1;
    case (w_type)
      BT_TS: begin
        if (w_beat == 2'd0) w_bypass = 4'b0001;
        else if (w_beat == 2'd3 && bus.ts_dc_bypass_i) w_bypass = 4'b1100;
      end
      BT_OTHER:         if (w_beat == 2'd0) w_bypass = 4'b0001;
      BT_EIEOS, BT_BYP: w_bypass = '1;
      BT_SKP: begin
        w_bypass  = '1;
        w_advance = '0;
      end
      default: ;
    endcase
  end

  for (genvar g = 0; g < 4; g++) begin : g_byte
    gen3_byte_scramble u_byte (
      .i_lfsr    (w_chain[g]),
      .i_data    (bus.data_in_i[8*g +: 8]),
      .i_bypass  (w_bypass[g]),
      .i_advance (w_advance[g]),
      .o_data    (w_data[8*g +: 8]),
      .o_lfsr    (w_chain[g+1])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt    <= '0;
      r_type   <= BT_DATA;
      r_lfsr   <= '0;
      r_seeded <= 1'b0;
      r_valid  <= 1'b0;
      r_start  <= 1'b0;
      r_sync   <= '0;
      r_data   <= '0;
      r_err    <= 1'b0;
    end else begin
      r_valid <= bus.data_valid_i;
      r_start <= bus.data_valid_i & bus.block_start_i;
      r_sync  <= bus.sync_header_i;
      r_data  <= w_data;
      r_err   <= bus.data_valid_i & w_err;
      if (bus.data_valid_i) begin
        r_cnt    <= w_beat + 2'd1;
        r_type   <= w_type;
        r_lfsr   <= w_chain[4];
        r_seeded <= !(w_type == BT_EIEOS && w_beat == 2'd3);
      end
      if (bus.scramble_reset_i) r_seeded <= 1'b0;
    end
  end

  assign bus.data_valid_o  = r_valid;
  assign bus.block_start_o = r_start;
  assign bus.sync_header_o = r_sync;
  assign bus.data_out_o    = r_data;
  assign bus.block_err_o   = r_err;

endmodule

// File: tb/tb_gen3_scramble.sv
// Directed bench for gen3_scramble with a serial reference LFSR model and an
// expected-beat scoreboard.
module tb_gen3_scramble;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] lane_number;

  gen3_scramble_if bus ();

  gen3_scramble #(.LANES_LOG2(3)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .lane_number (lane_number),
    .bus         (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    logic        start;
    logic [1:0]  sync;
    logic        err;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] outlog [$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;

  localparam int T_DATA = 0, T_TS = 1, T_EIEOS = 2, T_BYP = 3, T_SKP = 4, T_OTH = 5;
  logic [22:0] SEEDS [8] = '{23'h1DBFBC, 23'h0607BB, 23'h1EC760, 23'h18C0DB,
                             23'h010F12, 23'h19CFC9, 23'h0277CE, 23'h1BB807};
  logic [22:0] m_lfsr;
  int          m_cnt;
  int          m_type;
  logic [7:0]  blk [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [22:0] step(input logic [22:0] s);
    return s[22] ? ({s[21:0], 1'b0} ^ 23'h210125) : {s[21:0], 1'b0};
  endfunction

  task automatic model_reset();
    m_lfsr = SEEDS[lane_number[2:0]];
    m_cnt  = 0;
    m_type = T_DATA;
  endtask

  task automatic model_beat(input logic start, input logic [1:0] sync, input logic [31:0] data,
                            input logic tsdc, input logic srst, output exp_t e);
    int b;
    logic err;
    err = 1'b0;
    if (start) begin
      if (m_cnt != 0) err = 1'b1;
      b = 0;
    end else b = m_cnt;
    if (b == 0) begin
      if (!start) begin m_type = T_DATA; err = 1'b1; end
      else if (sync == 2'b01) m_type = T_DATA;
      else if (sync == 2'b10) begin
        case (data[7:0])
          8'h00:               m_type = T_EIEOS;
          8'h1E, 8'h2D:        m_type = T_TS;
          8'hAA:               m_type = T_SKP;
          8'h66, 8'h55, 8'hE1: m_type = T_BYP;
          default: begin m_type = T_OTH; err = 1'b1; end
        endcase
      end else begin m_type = T_DATA; err = 1'b1; end
    end
    for (int j = 0; j < 4; j++) begin
      int n;
      logic [7:0] d, key;
      logic byp, adv;
      n = 4*b + j;
      d = data[8*j +: 8];
      byp = 1'b0;
      adv = 1'b1;
      case (m_type)
        T_TS:            byp = (n == 0) || (n >= 14 && tsdc);
        T_OTH:           byp = (n == 0);
        T_EIEOS, T_BYP:  byp = 1'b1;
        T_SKP: begin byp = 1'b1; adv = 1'b0; end
        default: ;
      endcase
      for (int i = 0; i < 8; i++) key[i] = m_lfsr[22-i];
      e.data[8*j +: 8] = byp ? d : (d ^ key);
      if (adv) repeat (8) m_lfsr = step(m_lfsr);
    end
    if (m_type == T_EIEOS && b == 3) m_lfsr = SEEDS[lane_number[2:0]];
    if (srst) m_lfsr = SEEDS[lane_number[2:0]];
    m_cnt   = (b + 1) % 4;
    e.start = start;
    e.sync  = sync;
    e.err   = err;
  endtask

  task automatic beat(input logic start, input logic [1:0] sync, input logic [31:0] data,
                      input logic tsdc = 1'b0, input logic srst = 1'b0);
    exp_t e;
    @(negedge clk_i);
    bus.data_valid_i     = 1'b1;
    bus.block_start_i    = start;
    bus.sync_header_i    = sync;
    bus.data_in_i        = data;
    bus.ts_dc_bypass_i   = tsdc;
    bus.scramble_reset_i = srst;
    model_beat(start, sync, data, tsdc, srst, e);
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_i);
      bus.data_valid_i     = 1'b0;
      bus.block_start_i    = 1'b0;
      bus.scramble_reset_i = 1'b0;
      bus.ts_dc_bypass_i   = 1'b0;
      bus.data_in_i        = '0;
    end
  endtask

  task automatic block(input logic [1:0] sync, input logic [7:0] s [16], input logic tsdc);
    for (int k = 0; k < 4; k++)
      beat(k == 0, sync, {s[4*k+3], s[4*k+2], s[4*k+1], s[4*k]}, tsdc);
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 16; i++) blk[i] = v;
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && bus.data_valid_o === 1'b1) begin
      outlog.push_back(bus.data_out_o);
      if (sb.size() == 0) check("unexpected_beat", 32'd1, 32'd0);
      else begin
        mon_e = sb.pop_front();
        check("data_out", bus.data_out_o, mon_e.data);
        check("block_start", 32'(bus.block_start_o), 32'(mon_e.start));
        check("sync_header", 32'(bus.sync_header_o), 32'(mon_e.sync));
        check("block_err", 32'(bus.block_err_o), 32'(mon_e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_mid_block(input logic [7:0] lane);
    beat(1'b1, 2'b01, 32'h0);
    beat(1'b0, 2'b01, 32'h0);
    idle(1);
    #2 rst_i = 1'b1;
    #1;
    check("rst_valid", 32'(bus.data_valid_o), 32'd0);
    check("rst_data", bus.data_out_o, 32'd0);
    check("rst_err", 32'(bus.block_err_o), 32'd0);
    lane_number = lane;
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
    fill(8'h00);
    block(2'b01, blk, 1'b0);
    idle(2);
  endtask

  initial begin
    rst_i = 1'b1;
    lane_number = 8'd0;
    bus.data_valid_i = 1'b0;  bus.block_start_i = 1'b0;  bus.sync_header_i = 2'b00;
    bus.data_in_i = '0;       bus.ts_dc_bypass_i = 1'b0; bus.scramble_reset_i = 1'b0;
    #12;
    check("reset_valid", 32'(bus.data_valid_o), 32'd0);
    check("reset_start", 32'(bus.block_start_o), 32'd0);
    check("reset_sync", 32'(bus.sync_header_o), 32'd0);
    check("reset_data", bus.data_out_o, 32'd0);
    check("reset_err", 32'(bus.block_err_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();

    // 1: DATA zeros expose the raw keystream
    fill(8'h00);
    block(2'b01, blk, 1'b0);

    // 2: SKP block then DATA
    fill(8'hAA);
    blk[12] = 8'hE1; blk[13] = 8'h12; blk[14] = 8'h34; blk[15] = 8'h56;
    block(2'b10, blk, 1'b0);
    fill(8'h00);
    block(2'b01, blk, 1'b0);

    // 3: EIEOS then DATA
    for (int i = 0; i < 16; i++) blk[i] = (i % 2) ? 8'hFF : 8'h00;
    idle(2);
    outlog.delete();
    block(2'b10, blk, 1'b0);
    idle(2);
    check("eieos_w0", outlog[0], 32'hFF00FF00);
    check("eieos_w3", outlog[3], 32'hFF00FF00);
    fill(8'h5A);
    block(2'b01, blk, 1'b0);

    // 4: TS1 with and without DC-balance bypass, then TS2
    blk[0] = 8'h1E; blk[1] = 8'hF7; blk[2] = 8'hF7; blk[3] = 8'h0F; blk[4] = 8'h02; blk[5] = 8'h00;
    for (int i = 6; i < 14; i++) blk[i] = 8'h4A;
    blk[14] = 8'hDC; blk[15] = 8'hB3;
    idle(2);
    outlog.delete();
    block(2'b10, blk, 1'b1);
    idle(2);
    check("ts1_sym0", 32'(outlog[0][7:0]), 32'h1E);
    check("ts1_sym14_15", 32'(outlog[3][31:16]), 32'hB3DC);
    block(2'b10, blk, 1'b0);
    blk[0] = 8'h2D;
    block(2'b10, blk, 1'b1);

    // 5: framing errors, gaps, other ordered sets, scramble reset
    beat(1'b1, 2'b01, 32'h11223344);
    idle(1);
    beat(1'b0, 2'b01, 32'h55667788);
    beat(1'b1, 2'b11, 32'h99AABBCC);
    idle(2);
    beat(1'b0, 2'b11, 32'hDEADBEEF);
    beat(1'b0, 2'b11, 32'h01234567);
    idle(1);
    beat(1'b0, 2'b11, 32'h89ABCDEF);
    beat(1'b0, 2'b01, 32'hCAFEF00D);
    beat(1'b0, 2'b01, 32'h0);
    beat(1'b0, 2'b01, 32'h0);
    beat(1'b0, 2'b01, 32'h0);
    fill(8'h66);
    block(2'b10, blk, 1'b0);
    fill(8'h77);
    block(2'b10, blk, 1'b0);
    beat(1'b1, 2'b01, 32'h0);
    beat(1'b0, 2'b01, 32'h0, 1'b0, 1'b1);
    beat(1'b0, 2'b01, 32'h0);
    beat(1'b0, 2'b01, 32'h0);
    idle(2);

    // 6: asynchronous reset mid-block on lanes 0 and 5
    reset_mid_block(8'd0);
    reset_mid_block(8'd5);

    idle(3);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
